compare_arbiter: RTL
====================

COMPARE_ARBITER -- requirements
Module: compare_arbiter

Interface
REQ-001: The block SHALL have parameter W, default 8, giving the width of each requester's priority value.
REQ-002: The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003: The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004: The block SHALL have port req_a, input, 1, access request from requester A.
REQ-005: The block SHALL have port req_b, input, 1, access request from requester B.
REQ-006: The block SHALL have port val_a, input, W, priority value of A.
REQ-007: The block SHALL have port val_b, input, W, priority value of B.
REQ-008: The block SHALL have port grant_a, output, 1, registered grant to A.
REQ-009: The block SHALL have port grant_b, output, 1, registered grant to B.
REQ-010: The block SHALL have port win_val, output, W, captured value of the current grantee; 0 when there is no grant.
REQ-011: The block SHALL have port busy, output, 1, high in COMPARE state.
REQ-012: The block SHALL have port cmp_cycles, output, 4, number of COMPARE cycles used by the most recent arbitration.

Function
REQ-013: The block SHALL implement the FSM states IDLE, COMPARE and GRANT; grant_a and grant_b SHALL never be high together.
REQ-014: In IDLE with exactly one request high, the block SHALL capture that requester's value, go to GRANT for it, and load cmp_cycles=0; the grant SHALL be high after 1 edge.
REQ-015: In IDLE with both requests high, the block SHALL capture val_a and val_b into internal registers, set bit index to W-1, and enter COMPARE; input value changes after capture SHALL be ignored.
REQ-016: COMPARE SHALL examine one bit per cycle, MSB first, of the captured values, incrementing the cycle counter on each such cycle.
- Bits differ: the requester holding 1 wins; go to GRANT.
- Bits equal and index>0: decrement index; stay in COMPARE.
- Bits equal and index=0 (tie): the winner SHALL be the requester that did not win the last grant (round-robin).
REQ-017: Latency SHALL be fixed by the first differing bit position k: W-k COMPARE cycles; the grant SHALL be high after W-k+1 edges from the IDLE sampling edge; a tie SHALL take W COMPARE cycles.
REQ-018: If exactly one request is low during a COMPARE cycle, the block SHALL abort and go to GRANT for the remaining requester.
REQ-019: If both requests are low during a COMPARE cycle, the block SHALL abort to IDLE with no grant; in both abort cases cmp_cycles SHALL take the count reached.
REQ-020: On entering GRANT, the block SHALL record the last-winner flag and set win_val to the winner's captured value.
REQ-021: GRANT SHALL hold while the grantee's request is high, regardless of the other request or of value changes.
REQ-022: When the grantee's request is low in GRANT, the block SHALL drop the grant and clear win_val at that edge and return to IDLE; re-arbitration SHALL start from IDLE on the following edge (one idle cycle minimum between grants).
REQ-023: cmp_cycles SHALL update only on entry to GRANT or on an abort to IDLE, and SHALL saturate at W (W≤15).

Reset
REQ-024: While rst_n is low, the block SHALL force state=IDLE, grant_a=0, grant_b=0, win_val=0, busy=0 and cmp_cycles=0 immediately, independent of clk.
REQ-025: While rst_n is low, the block SHALL clear the captured values and set the last-winner flag to B, so that the first tie after reset grants A.
REQ-026: Reset asserted in any state, including mid-COMPARE or GRANT, SHALL discard the arbitration in progress; after release the block SHALL arbitrate afresh from IDLE.

Verification
REQ-027: The bench SHALL drive req_a only with val_a=0x10 -> grant_a=1 after 1 edge, win_val=0x10, cmp_cycles=0, busy never high.
REQ-028: The bench SHALL drive both requests with val_a=0x80, val_b=0x7F -> 1 COMPARE cycle, grant_a after 2 edges, win_val=0x80, cmp_cycles=1.
REQ-029: The bench SHALL drive both requests with val_a=0x04, val_b=0x05 -> 8 COMPARE cycles, grant_b after 9 edges, win_val=0x05, cmp_cycles=8.
REQ-030: The bench SHALL run two back-to-back ties with both values 0x33 after reset -> first grant_a, after release second grant_b, each with cmp_cycles=8.
REQ-031: The bench SHALL drop req_b at the 3rd COMPARE cycle with val_a=val_b=0x0F -> grant_a at that edge, cmp_cycles=3; the bench SHALL then drop req_a -> grant_a=0 and win_val=0 at the next edge.
REQ-032: The bench SHALL pulse rst_n low mid-COMPARE -> all outputs 0 asynchronously; after release with both requests still high, arbitration SHALL restart with full latency.

Source files
------------

// File: rtl/compare_arbiter_if.sv
`default_nettype none
// ============================================================================
// compare_arbiter_if : request/value/grant bundle for compare_arbiter
// Revision 1.0 : initial release
// ============================================================================
interface compare_arbiter_if #(
  parameter int W = 8
);
  logic         req_a;
  logic         req_b;
  logic [W-1:0] val_a;
  logic [W-1:0] val_b;
  logic         grant_a;
  logic         grant_b;
  logic [W-1:0] win_val;
  logic         busy;
  logic [3:0]   cmp_cycles;

  modport master (
    output req_a, req_b, val_a, val_b,
    input  grant_a, grant_b, win_val, busy, cmp_cycles
  );

  modport slave (
    input  req_a, req_b, val_a, val_b,
    output grant_a, grant_b, win_val, busy, cmp_cycles
  );
endinterface
`default_nettype wire

// File: rtl/compare_arbiter.sv
`default_nettype none
// ============================================================================
// compare_arbiter : two-requester arbiter, bit-serial MSB-first value compare
// Revision 1.0 : initial release
// ============================================================================
module compare_arbiter #(
  parameter int W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  compare_arbiter_if.slave bus
);
  localparam int c_iw = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_GRANT   = 2'd2
  } state_t;

  state_t          r_state,      w_state_nx;
  logic [W-1:0]    r_cap_a,      w_cap_a_nx;
  logic [W-1:0]    r_cap_b,      w_cap_b_nx;
  logic [c_iw-1:0] r_idx,        w_idx_nx;
  logic [3:0]      r_cnt,        w_cnt_nx;
  logic [3:0]      r_cmp_cycles, w_cmp_cycles_nx;
  logic            r_grant_a,    w_grant_a_nx;
  logic            r_grant_b,    w_grant_b_nx;
  logic [W-1:0]    r_win_val,    w_win_val_nx;
  logic            r_last_a,     w_last_a_nx;

  logic            w_go_grant;
  logic            w_pick_a;
  logic [W-1:0]    w_pick_val;
  logic [3:0]      w_cnt_inc;
  logic            w_bit_a;
  logic            w_bit_b;

  assign w_cnt_inc = (r_cnt >= 4'(W)) ? 4'(W) : r_cnt + 4'd1;
  assign w_bit_a   = r_cap_a[r_idx];
  assign w_bit_b   = r_cap_b[r_idx];

  always_comb begin
    w_state_nx      = r_state;
    w_cap_a_nx      = r_cap_a;
    w_cap_b_nx      = r_cap_b;
    w_idx_nx        = r_idx;
    w_cnt_nx        = r_cnt;
    w_cmp_cycles_nx = r_cmp_cycles;
    w_grant_a_nx    = r_grant_a;
    w_grant_b_nx    = r_grant_b;
    w_win_val_nx    = r_win_val;
    w_last_a_nx     = r_last_a;
    w_go_grant      = 1'b0;
    w_pick_a        = 1'b0;
    w_pick_val      = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_a && bus.req_b) begin
          w_cap_a_nx = bus.val_a;
          w_cap_b_nx = bus.val_b;
          w_idx_nx   = c_iw'(W - 1);
          w_cnt_nx   = 4'd0;
          w_state_nx = S_COMPARE;
        end else if (bus.req_a || bus.req_b) begin
          w_go_grant      = 1'b1;
          w_pick_a        = bus.req_a;
          w_pick_val      = bus.req_a ? bus.val_a : bus.val_b;
          w_cap_a_nx      = bus.req_a ? bus.val_a : r_cap_a;
          w_cap_b_nx      = bus.req_a ? r_cap_b : bus.val_b;
          w_cmp_cycles_nx = 4'd0;
        end
      end

      S_COMPARE: begin
        // Every COMPARE cycle counts, including the one on which an abort is seen.
        w_cnt_nx = w_cnt_inc;
        if (!bus.req_a && !bus.req_b) begin
          w_cmp_cycles_nx = w_cnt_inc;
          w_state_nx      = S_IDLE;
        end else if (!bus.req_a || !bus.req_b) begin
          w_go_grant      = 1'b1;
          w_pick_a        = bus.req_a;
          w_cmp_cycles_nx = w_cnt_inc;
        end else if (w_bit_a != w_bit_b) begin
          w_go_grant      = 1'b1;
          w_pick_a        = w_bit_a;
          w_cmp_cycles_nx = w_cnt_inc;
        end else if (r_idx != '0) begin
          w_idx_nx = r_idx - 1'b1;
        end else begin
          // Full tie: alternate away from whoever won last.
          w_go_grant      = 1'b1;
          w_pick_a        = !r_last_a;
          w_cmp_cycles_nx = w_cnt_inc;
        end
        w_pick_val = w_pick_a ? r_cap_a : r_cap_b;
      end

      S_GRANT: begin
        if ((r_grant_a && !bus.req_a) || (r_grant_b && !bus.req_b)) begin
          w_grant_a_nx = 1'b0;
          w_grant_b_nx = 1'b0;
          w_win_val_nx = '0;
          w_state_nx   = S_IDLE;
        end
      end

      default: begin
        w_grant_a_nx = 1'b0;
        w_grant_b_nx = 1'b0;
        w_win_val_nx = '0;
        w_state_nx   = S_IDLE;
      end
    endcase

    if (w_go_grant) begin
      w_grant_a_nx = w_pick_a;
      w_grant_b_nx = !w_pick_a;
      w_win_val_nx = w_pick_val;
      w_last_a_nx  = w_pick_a;
      w_state_nx   = S_GRANT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cap_a      <= '0;
      r_cap_b      <= '0;
      r_idx        <= '0;
      r_cnt        <= 4'd0;
      r_cmp_cycles <= 4'd0;
      r_grant_a    <= 1'b0;
      r_grant_b    <= 1'b0;
      r_win_val    <= '0;
      r_last_a     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cap_a      <= w_cap_a_nx;
      r_cap_b      <= w_cap_b_nx;
      r_idx        <= w_idx_nx;
      r_cnt        <= w_cnt_nx;
      r_cmp_cycles <= w_cmp_cycles_nx;
      r_grant_a    <= w_grant_a_nx;
      r_grant_b    <= w_grant_b_nx;
      r_win_val    <= w_win_val_nx;
      r_last_a     <= w_last_a_nx;
    end
  end

  assign bus.grant_a    = r_grant_a;
  assign bus.grant_b    = r_grant_b;
  assign bus.win_val    = r_win_val;
  assign bus.busy       = (r_state == S_COMPARE);
  assign bus.cmp_cycles = r_cmp_cycles;
endmodule
`default_nettype wire
